// File: rtl/fetch_pc_ctrl.sv
// IF-stage PC controller: boot, sequential fetch, ID redirects buffered across stalls, flushes.
// Optional FETCH_ALIGN_CHECK_EN builds the misaligned-fetch flag on addr_err.
module fetch_pc_ctrl #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  rom_en,
    output logic                  redirect_pending,
    output logic                  addr_err
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HOLD
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic                  w_pc_load;
    logic [ADDR_WIDTH-1:0] r_pend;
    logic [ADDR_WIDTH-1:0] w_pend_nxt;
    logic                  r_pending;
    logic                  w_pending_nxt;
    logic                  r_rom_en;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pc_load     = 1'b0;
        w_pend_nxt    = r_pend;
        w_pending_nxt = r_pending;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (flush) begin
                    w_pc_nxt  = exc_pc;
                    w_pc_load = 1'b1;
                end else if (stall && branch_flag) begin
                    w_pend_nxt    = branch_addr;
                    w_pending_nxt = 1'b1;
                    w_state_nxt   = S_HOLD;
                end else if (stall) begin
                    w_pc_load = 1'b0;
                end else if (branch_flag) begin
                    w_pc_nxt  = branch_addr;
                    w_pc_load = 1'b1;
                end else begin
                    w_pc_nxt  = r_pc + ADDR_WIDTH'(4);
                    w_pc_load = 1'b1;
                end
            end
            S_HOLD: begin
                // ID only holds a bubble here, so branch_flag is not looked at
                if (flush) begin
                    w_pc_nxt      = exc_pc;
                    w_pc_load     = 1'b1;
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = S_RUN;
                end else if (!stall) begin
                    w_pc_nxt      = r_pend;
                    w_pc_load     = 1'b1;
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_VECTOR;
            r_pend    <= '0;
            r_pending <= 1'b0;
            r_rom_en  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend    <= w_pend_nxt;
            r_pending <= w_pending_nxt;
            r_rom_en  <= (w_state_nxt != S_BOOT);
            if (w_pc_load) begin
                r_pc <= w_pc_nxt;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_addr_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_err <= 1'b0;
        end else if (w_pc_load) begin
            r_addr_err <= |w_pc_nxt[1:0];
        end
    end

    assign addr_err = r_addr_err;
`else
    assign addr_err = 1'b0;
`endif

    assign pc               = r_pc;
    assign rom_en           = r_rom_en;
    assign redirect_pending = r_pending;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: reference model compared every cycle plus literal checks.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RV = 32'hBFC00000;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] exc_pc = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [31:0] pc;
    logic        rom_en;
    logic        redirect_pending;
    logic        addr_err;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .exc_pc           (exc_pc),
        .branch_flag      (branch_flag),
        .branch_addr      (branch_addr),
        .pc               (pc),
        .rom_en           (rom_en),
        .redirect_pending (redirect_pending),
        .addr_err         (addr_err)
    );

    // Reference model of the fetch rules
    logic        m_live;
    logic [31:0] m_pc;
    logic        m_rom;
    logic        m_pend_v;
    logic [31:0] m_pend;
    logic        m_err;

    function automatic logic mis(input logic [31:0] a);
        return ERR_ON && (a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] seq_pc(input logic b, input logic [31:0] ba,
                                           input logic [31:0] cur);
        return b ? ba : cur + 32'd4;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_live   <= 1'b0;
            m_pc     <= RV;
            m_rom    <= 1'b0;
            m_pend_v <= 1'b0;
            m_pend   <= '0;
            m_err    <= 1'b0;
        end else if (!m_live) begin
            m_live <= 1'b1;
            m_rom  <= 1'b1;
        end else if (flush) begin
            m_pc     <= exc_pc;
            m_pend_v <= 1'b0;
            m_err    <= mis(exc_pc);
        end else if (m_pend_v) begin
            if (!stall) begin
                m_pc     <= m_pend;
                m_pend_v <= 1'b0;
                m_err    <= mis(m_pend);
            end
        end else if (stall) begin
            if (branch_flag) begin
                m_pend   <= branch_addr;
                m_pend_v <= 1'b1;
            end
        end else begin
            m_pc  <= seq_pc(branch_flag, branch_addr, m_pc);
            m_err <= mis(seq_pc(branch_flag, branch_addr, m_pc));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_pc", pc, m_pc);
        chk("model_rom_en", {31'd0, rom_en}, {31'd0, m_rom});
        chk("model_pending", {31'd0, redirect_pending}, {31'd0, m_pend_v});
        chk("model_addr_err", {31'd0, addr_err}, {31'd0, m_err});
    end

    task automatic cyc(input logic s, input logic f, input logic [31:0] e,
                       input logic b, input logic [31:0] a);
        @(negedge clk);
        stall       = s;
        flush       = f;
        exc_pc      = e;
        branch_flag = b;
        branch_addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, RV);
        chk("rst_rom_en", {31'd0, rom_en}, 32'd0);
        chk("rst_pending", {31'd0, redirect_pending}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("boot_rom_en", {31'd0, rom_en}, 32'd0);
        chk("boot_pc", pc, RV);
        @(posedge clk);
        #1;
        chk("run_rom_en", {31'd0, rom_en}, 32'd1);
        chk("run_pc_held", pc, RV);
        idle();
        chk("seq_pc4", pc, 32'hBFC00004);
        idle();
        chk("seq_pc8", pc, 32'hBFC00008);

        cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC00010);
        chk("br_pc10", pc, 32'hBFC00010);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC00100);
        chk("br_pc100", pc, 32'hBFC00100);
        idle();
        chk("br_pc104", pc, 32'hBFC00104);

        cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC00020);
        chk("br_pc20", pc, 32'hBFC00020);
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 32'h80000040);
        chk("hold_pc", pc, 32'hBFC00020);
        chk("hold_pending", {31'd0, redirect_pending}, 32'd1);
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 32'h11110000);
        chk("hold_ign_br", pc, 32'hBFC00020);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("hold_pc3", pc, 32'hBFC00020);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'h22220000);
        chk("hold_release_pc", pc, 32'h80000040);
        chk("hold_release_pend", {31'd0, redirect_pending}, 32'd0);
        idle();
        chk("after_release", pc, 32'h80000044);

        cyc(1'b1, 1'b0, 32'd0, 1'b1, 32'h80000040);
        chk("hold2_pending", {31'd0, redirect_pending}, 32'd1);
        cyc(1'b1, 1'b1, 32'hBFC00380, 1'b0, 32'd0);
        chk("hold_flush_pc", pc, 32'hBFC00380);
        chk("hold_flush_pend", {31'd0, redirect_pending}, 32'd0);
        idle();
        chk("pend_discarded", pc, 32'hBFC00384);

        cyc(1'b0, 1'b1, 32'hBFC00380, 1'b1, 32'h00001234);
        chk("flush_beats_br", pc, 32'hBFC00380);
        cyc(1'b1, 1'b1, 32'hBFC00200, 1'b0, 32'd0);
        chk("flush_beats_stall", pc, 32'hBFC00200);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFC);
        chk("br_top", pc, 32'hFFFFFFFC);
        idle();
        chk("wrap_zero", pc, 32'h00000000);
        idle();
        chk("wrap_four", pc, 32'h00000004);

        cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC00102);
        chk("mis_pc", pc, 32'hBFC00102);
        chk("mis_err", {31'd0, addr_err}, {31'd0, ERR_ON});
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC00200);
        chk("mis_clear", {31'd0, addr_err}, 32'd0);
        cyc(1'b0, 1'b1, 32'hBFC00381, 1'b0, 32'd0);
        chk("mis_flush_err", {31'd0, addr_err}, {31'd0, ERR_ON});
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 32'h80000041);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("mis_pend_pc", pc, 32'h80000041);
        chk("mis_pend_err", {31'd0, addr_err}, {31'd0, ERR_ON});

        cyc(1'b1, 1'b0, 32'd0, 1'b1, 32'h80000040);
        chk("pre_rst_pending", {31'd0, redirect_pending}, 32'd1);
        @(negedge clk);
        stall       = 1'b0;
        branch_flag = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_pc", pc, RV);
        chk("async_rst_rom", {31'd0, rom_en}, 32'd0);
        chk("async_rst_pend", {31'd0, redirect_pending}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reboot_pc", pc, RV);
        chk("reboot_rom", {31'd0, rom_en}, 32'd1);
        idle();
        chk("reboot_seq", pc, 32'hBFC00004);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
